// File: rtl/pooling_engine_if.sv
// Stream bundle between the systolic array and pooling_engine: skewed per-column pixels in and pooled results out.
// Stream semantics: valid-only, no back-pressure. A beat is consumed on each rising clk edge where valid is 1.
// Column j of in_data is valid j cycles after in_valid. out_valid[j] qualifies out_data[j*DATA_WIDTH +: DATA_WIDTH].
interface pooling_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COLS       = 32
);
  logic                       in_valid;
  logic [COLS*DATA_WIDTH-1:0] in_data;
  logic [COLS-1:0]            out_valid;
  logic [COLS*DATA_WIDTH-1:0] out_data;

  modport master (output in_valid, output in_data, input out_valid, input out_data);
  modport slave  (input in_valid, input in_data, output out_valid, output out_data);
endinterface

// File: rtl/pooling_engine.sv
// 2x2 stride-2 max/avg pooling over COLS skewed channel columns, one column-0 FSM with a skewed tag line.
// Optional macro POOL_RELU_EN: clamp negative pooled results to zero.
module pooling_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int COLS       = 32,
  parameter int MAX_W      = 64,
  parameter int MAX_H      = 64
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0]   cfg_height,
  input  logic                         cfg_mode,
  pooling_engine_if.slave              stream,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic [1:0]                   state_dbg
);
  localparam int DW    = DATA_WIDTH;
  localparam int SW    = DW + 2;
  localparam int WW    = $clog2(MAX_W+1);
  localparam int HW    = $clog2(MAX_H+1);
  localparam int DEPTH = MAX_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DCW   = $clog2(COLS+2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic          vld;
    logic          c0;
    logic          r0;
    logic [AW-1:0] addr;
    logic          last;
  } tag_t;

  state_t         state_q, state_d;
  logic [WW-1:0]  w_q, c_q;
  logic [HW-1:0]  h_q, r_q;
  logic           mode_q;
  logic [DCW-1:0] drain_q;
  logic           cfg_err_q;
  logic           cfg_ok, accept, last_px, launch;
  tag_t           tag0;
  tag_t           tag_q   [COLS-1];
  tag_t           tag_col [COLS];

  assign cfg_ok = !cfg_width[0] && !cfg_height[0] &&
                  (cfg_width  >= WW'(2)) && (cfg_width  <= WW'(MAX_W)) &&
                  (cfg_height >= HW'(2)) && (cfg_height <= HW'(MAX_H));
  assign launch  = (state_q == S_IDLE) && start && cfg_ok;
  assign accept  = (state_q == S_RUN) && stream.in_valid;
  assign last_px = (c_q == w_q - WW'(1)) && (r_q == h_q - HW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RUN;
      S_RUN:   if (accept && last_px) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == DCW'(COLS)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      mode_q    <= 1'b0;
      c_q       <= '0;
      r_q       <= '0;
      drain_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
      drain_q   <= (state_q == S_DRAIN) ? drain_q + DCW'(1) : '0;
      if (launch) begin
        w_q    <= cfg_width;
        h_q    <= cfg_height;
        mode_q <= cfg_mode;
        c_q    <= '0;
        r_q    <= '0;
      end else if (accept) begin
        if (c_q == w_q - WW'(1)) begin
          c_q <= '0;
          r_q <= r_q + HW'(1);
        end else begin
          c_q <= c_q + WW'(1);
        end
      end
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign state_dbg = state_q;

  always_comb begin
    tag0      = '0;
    tag0.vld  = accept;
    tag0.c0   = c_q[0];
    tag0.r0   = r_q[0];
    tag0.addr = AW'(c_q >> 1);
    tag0.last = accept && last_px;
  end

  // One register per column hop keeps each column's tag aligned with its skewed pixel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < COLS-1; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag0;
      for (int k = 1; k < COLS-1; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    if (j == 0) begin : g_head
      assign tag_col[j] = tag0;
    end else begin : g_tail
      assign tag_col[j] = tag_q[j-1];
    end

    tag_t                 tg;
    logic signed [DW-1:0] px;
    logic signed [SW-1:0] px_x, pair_q, h, bufv, pool_sum, avg_x, max_x, res_x;
    logic signed [DW-1:0] res, res_fin;
    logic signed [SW-1:0] lbuf [DEPTH];
    logic                 out_v_q;
    logic        [DW-1:0] out_d_q;

    assign tg   = tag_col[j];
    assign px   = stream.in_data[j*DW +: DW];
    assign px_x = {{2{px[DW-1]}}, px};
    assign h    = mode_q ? (pair_q + px_x) : ((pair_q > px_x) ? pair_q : px_x);
    assign bufv = lbuf[tg.addr];
    assign pool_sum = bufv + h;
    assign avg_x    = pool_sum >>> 2;
    assign max_x    = (bufv > h) ? bufv : h;
    assign res_x    = mode_q ? avg_x : max_x;
    assign res      = res_x[DW-1:0];

`ifdef POOL_RELU_EN
    assign res_fin = res[DW-1] ? '0 : res;
`else
    assign res_fin = res;
`endif

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        pair_q  <= '0;
        out_v_q <= 1'b0;
        out_d_q <= '0;
      end else begin
        out_v_q <= 1'b0;
        if (tg.vld && !tg.c0) pair_q <= px_x;
        if (tg.vld && tg.c0 && tg.r0) begin
          out_v_q <= 1'b1;
          out_d_q <= res_fin;
        end
      end
    end

    // Line buffer holds even-row horizontal partials; contents are don't-care after reset.
    always_ff @(posedge clk) begin
      if (tg.vld && tg.c0 && !tg.r0) lbuf[tg.addr] <= h;
    end

    assign stream.out_valid[j]          = out_v_q;
    assign stream.out_data[j*DW +: DW]  = out_d_q;
  end
endmodule

// File: tb/tb_pooling_engine.sv
// Bench for pooling_engine: random skewed images per column against a 2x2 pooling reference model.
module tb_pooling_engine;
  localparam int DW = 16, COLS = 32, MAX_W = 64, MAX_H = 64, MAXPIX = 256;

  logic       clk = 1'b0, nrst = 1'b0, start = 1'b0;
  logic [6:0] cfg_width = '0, cfg_height = '0;
  logic       cfg_mode = 1'b0;
  logic       busy, done, cfg_err;
  logic [1:0] state_dbg;

  pooling_engine_if #(.DATA_WIDTH(DW), .COLS(COLS)) bus ();

  pooling_engine #(.DATA_WIDTH(DW), .COLS(COLS), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk(clk), .nrst(nrst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_mode(cfg_mode), .stream(bus.slave), .busy(busy), .done(done), .cfg_err(cfg_err),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model state and scoreboard
  int img [COLS][MAXPIX];
  int exp_v [COLS][$];
  int exp_t [COLS][$];
  int got0 [$];
  int want_q [$];
  int exp_done = -1;
  int done_cnt = 0, cfg_err_cnt = 0;
  logic signed [DW-1:0] mon_px;

  function automatic int pool_ref(int j, int w, bit mode, int br, int bc);
    int a, b, c, d, s, q;
    a = img[j][2*br*w + 2*bc];
    b = img[j][2*br*w + 2*bc + 1];
    c = img[j][(2*br+1)*w + 2*bc];
    d = img[j][(2*br+1)*w + 2*bc + 1];
    if (mode) begin
      s = a + b + c + d;
      q = s / 4;
      if (s < 0 && (s % 4) != 0) q = q - 1;
    end else begin
      q = a;
      if (b > q) q = b;
      if (c > q) q = c;
      if (d > q) q = d;
    end
`ifdef POOL_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_time", cyc, exp_done);
    end
    if (cfg_err) cfg_err_cnt++;
    for (int j = 0; j < COLS; j++) begin
      if (bus.out_valid[j]) begin
        mon_px = $signed(bus.out_data[j*DW +: DW]);
        if (j == 0) got0.push_back(int'(mon_px));
        if (exp_v[j].size() == 0) begin
          check($sformatf("col%0d_extra", j), 1, 0);
        end else begin
          check($sformatf("col%0d_val", j), int'(mon_px), exp_v[j].pop_front());
          check($sformatf("col%0d_time", j), cyc, exp_t[j].pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic fill_random();
    for (int j = 0; j < COLS; j++)
      for (int p = 0; p < MAXPIX; p++) img[j][p] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic do_start(input int w, input int h, input bit mode);
    start = 1'b1; cfg_width = 7'(w); cfg_height = 7'(h); cfg_mode = mode;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic bad_start(input string tag, input int w, input int h);
    do_start(w, h, 1'b0);
    check({tag, "_err"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_err_once"}, cfg_err, 0);
    check({tag, "_still_idle"}, busy, 0);
  endtask

  task automatic check_col0(input string tag);
    check({tag, "_count"}, got0.size(), want_q.size());
    for (int i = 0; i < want_q.size(); i++)
      check($sformatf("%s_v%0d", tag, i), (i < got0.size()) ? got0[i] : -99999, want_q[i]);
  endtask

  task automatic run_job(input int w, input int h, input bit mode, input bit gaps,
                         input bit spurious, input int abort_at);
    bit sv [$];
    int sp [$];
    int len, base_done, base_err, left;
    len = w * h;
    for (int p = 0; p < len; p++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) begin sv.push_back(1'b0); sp.push_back(-1); end
      sv.push_back(1'b1); sp.push_back(p);
    end
    got0.delete();
    base_done = done_cnt;
    base_err  = cfg_err_cnt;
    do_start(w, h, mode);
    check("busy_run", busy, 1);
    for (int t = 0; t < sv.size() + COLS - 1; t++) begin
      if (t == abort_at) begin
        nrst = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", |bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        for (int j = 0; j < COLS; j++) begin exp_v[j].delete(); exp_t[j].delete(); end
        exp_done = -1;
        @(posedge clk); #3;
        nrst = 1'b1;
        repeat (COLS + 6) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - base_done, 0);
        check("abort_idle", busy, 0);
        return;
      end
      bus.in_valid = (t < sv.size()) ? sv[t] : 1'($urandom_range(0, 1));
      for (int j = 0; j < COLS; j++) begin
        int s;
        s = t - j;
        if (s >= 0 && s < sv.size() && sv[s]) bus.in_data[j*DW +: DW] = 16'(img[j][sp[s]]);
        else bus.in_data[j*DW +: DW] = 16'($urandom);
      end
      if (t < sv.size() && sv[t]) begin
        int p, r, c;
        p = sp[t]; r = p / w; c = p % w;
        if (r % 2 == 1 && c % 2 == 1)
          for (int j = 0; j < COLS; j++) begin
            exp_v[j].push_back(pool_ref(j, w, mode, r/2, c/2));
            exp_t[j].push_back(cyc + 1 + j);
          end
        if (p == len - 1) exp_done = cyc + COLS + 2;
      end
      start = spurious && (t == sv.size() / 2);
      if (start) begin cfg_width = 7'd2; cfg_height = 7'd2; cfg_mode = ~mode; end
      @(posedge clk); #1;
    end
    start = 1'b0; bus.in_valid = 1'b0;
    for (int k = 0; k < 200 && done_cnt == base_done; k++) @(posedge clk);
    @(posedge clk); #1;
    check("done_count", done_cnt - base_done, 1);
    check("busy_after_done", busy, 0);
    check("no_cfg_err", cfg_err_cnt - base_err, 0);
    left = 0;
    for (int j = 0; j < COLS; j++) left += exp_v[j].size();
    check("missing_outputs", left, 0);
    exp_done = -1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", |bus.out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cfg_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk); #1;

    // T1: 4x4 max, column 0 carries 1..16
    fill_random();
    for (int p = 0; p < 16; p++) img[0][p] = p + 1;
    run_job(4, 4, 1'b0, 1'b0, 1'b0, -1);
    want_q = '{6, 8, 14, 16};
    check_col0("t1");

    // T2: 2x2 average, floor toward -inf
    fill_random();
    img[0][0] = -1; img[0][1] = -2; img[0][2] = -2; img[0][3] = -2;
    run_job(2, 2, 1'b1, 1'b0, 1'b0, -1);
    want_q = '{-2};
    check_col0("t2a");
    img[0][0] = 3; img[0][1] = 3; img[0][2] = 3; img[0][3] = 2;
    run_job(2, 2, 1'b1, 1'b0, 1'b0, -1);
    want_q = '{2};
    check_col0("t2b");

    // T3: 4x4 max with bubbles
    fill_random();
    for (int p = 0; p < 16; p++) img[0][p] = p + 1;
    run_job(4, 4, 1'b0, 1'b1, 1'b0, -1);
    want_q = '{6, 8, 14, 16};
    check_col0("t3");

    // T4: rejected configurations, then a spurious start during RUN
    bad_start("w3", 3, 4);
    bad_start("w0", 0, 4);
    bad_start("w66", 66, 4);
    bad_start("h1", 4, 1);
    fill_random();
    run_job(8, 4, 1'b1, 1'b1, 1'b1, -1);

    // T5: reset mid-RUN, then a fresh 2x2 job
    fill_random();
    run_job(4, 4, 1'b0, 1'b0, 1'b0, 9);
    fill_random();
    run_job(2, 2, 1'b0, 1'b0, 1'b0, -1);

    // T6: all-negative max block
    fill_random();
    img[0][0] = -5; img[0][1] = -3; img[0][2] = -4; img[0][3] = -9;
    run_job(2, 2, 1'b0, 1'b0, 1'b0, -1);
`ifdef POOL_RELU_EN
    want_q = '{0};
`else
    want_q = '{-3};
`endif
    check_col0("t6");

    // randomized configurations
    for (int n = 0; n < 5; n++) begin
      fill_random();
      run_job(2 * $urandom_range(1, 8), 2 * $urandom_range(1, 8), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
